ddr2_arbiter: RTL and testbench

DDR2_ARBITER -- requirements
Module: ddr2_arbiter

---
 rtl/ddr2_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr2_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_arbiter.sv
//==============================================================================
// Module  : ddr2_arbiter
// Brief   : Write/read requester arbiter for a single DRAM command port with
//           burst-limited fairness. Define DDR2_ARBITER_STATS_EN for stat_*.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr2_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        ctrl_clk,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_CMD = 2'd1,
    RD_CMD = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

  state_t      r_state, w_state_nxt;
  logic        r_last_rd, w_last_rd_nxt;
  logic [7:0]  r_burst_cnt, w_burst_cnt_nxt;
  logic        w_own_req, w_other_req, w_keep, w_grant, w_grant_rd;
  logic        w_mem_write_nxt, w_mem_read_nxt, w_wr_ack_nxt, w_rd_ack_nxt;
  logic [31:0] w_mem_addr_nxt, w_mem_wdata_nxt, w_rd_data_nxt;

  // Last owner keeps the port until its burst allowance runs out while the other side waits.
  assign w_own_req   = r_last_rd ? rd_req : wr_req;
  assign w_other_req = r_last_rd ? wr_req : rd_req;
  assign w_keep      = w_own_req && (!w_other_req || (r_burst_cnt < c_max_burst));
  assign w_grant     = w_keep || w_other_req;
  assign w_grant_rd  = w_keep ? r_last_rd : ~r_last_rd;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_rd_nxt   = r_last_rd;
    w_burst_cnt_nxt = r_burst_cnt;
    w_mem_write_nxt = mem_write;
    w_mem_read_nxt  = mem_read;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_wr_ack_nxt    = 1'b0;
    w_rd_ack_nxt    = 1'b0;
    w_rd_data_nxt   = rd_data;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt     = w_grant_rd ? RD_CMD : WR_CMD;
          w_mem_write_nxt = ~w_grant_rd;
          w_mem_read_nxt  = w_grant_rd;
          w_mem_addr_nxt  = w_grant_rd ? rd_addr : wr_addr;
          if (!w_grant_rd)
            w_mem_wdata_nxt = wr_data;
          w_last_rd_nxt = w_grant_rd;
          if (w_grant_rd != r_last_rd)
            w_burst_cnt_nxt = 8'd1;
          else if (r_burst_cnt != 8'hFF)
            w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end
      end
      WR_CMD: begin
        if (!mem_waitrequest) begin
          w_state_nxt     = DONE;
          w_mem_write_nxt = 1'b0;
          w_wr_ack_nxt    = 1'b1;
        end
      end
      RD_CMD: begin
        if (!mem_waitrequest) begin
          w_state_nxt    = DONE;
          w_mem_read_nxt = 1'b0;
          w_rd_ack_nxt   = 1'b1;
          w_rd_data_nxt  = mem_rdata;
        end
      end
      default: w_state_nxt = IDLE;  // DONE: requests are deliberately not sampled here
    endcase
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_rd   <= 1'b0;
      r_burst_cnt <= 8'd0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      rd_data     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_rd   <= w_last_rd_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      mem_write   <= w_mem_write_nxt;
      mem_read    <= w_mem_read_nxt;
      mem_addr    <= w_mem_addr_nxt;
      mem_wdata   <= w_mem_wdata_nxt;
      wr_ack      <= w_wr_ack_nxt;
      rd_ack      <= w_rd_ack_nxt;
      rd_data     <= w_rd_data_nxt;
    end
  end

`ifdef DDR2_ARBITER_STATS_EN
  logic [31:0] r_stat_wr, r_stat_rd, r_stat_stall;

  // Completion counts advance on the same edge that raises the ack.
  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_wr    <= 32'd0;
      r_stat_rd    <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if (w_wr_ack_nxt)
        r_stat_wr <= r_stat_wr + 32'd1;
      if (w_rd_ack_nxt)
        r_stat_rd <= r_stat_rd + 32'd1;
      if ((mem_write || mem_read) && mem_waitrequest)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_wr_cnt    = r_stat_wr;
  assign stat_rd_cnt    = r_stat_rd;
  assign stat_stall_cnt = r_stat_stall;
`else
  assign stat_wr_cnt    = 32'd0;
  assign stat_rd_cnt    = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr2_arbiter.sv
// Bench for ddr2_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of arbitration, stalls and acks.
`default_nettype none

module tb_ddr2_arbiter;
  localparam int MAX_BURST = 8;
`ifdef DDR2_ARBITER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam int PH_READY = 0;
  localparam int PH_CMD   = 1;
  localparam int PH_ACK   = 2;

  logic        ctrl_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0, rd_addr = 32'd0;
  logic        wr_ack, rd_ack, mem_write, mem_read;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;

  ddr2_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_rdata(mem_rdata),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  int          m_phase, m_burst, m_stall_left;
  bit          m_side_rd, m_last_rd;
  bit          exp_write, exp_read, exp_wr_ack, exp_rd_ack;
  logic [31:0] exp_addr, exp_wdata, exp_rd_data, m_wr_cnt, m_rd_cnt, m_stall_cnt;

  // requester / memory agents
  bit          wr_pend, wr_granted, rd_pend, rd_granted;
  bit          auto_gen, allow_withdraw, allow_drop, rand_stall, rdata_fixed;
  logic [63:0] wr_plan[$];
  logic [31:0] rd_plan[$];
  int          stall_plan[$];

  // observation of the DUT
  int cyc, wr_cmd_cyc, rd_cmd_cyc, wr_ack_seen, rd_ack_seen;
  bit prev_cmd;
  int start_cyc[$];
  bit start_rd[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_READY; m_last_rd = 1'b0; m_burst = 0; m_stall_left = 0;
    exp_write = 1'b0; exp_read = 1'b0; exp_wr_ack = 1'b0; exp_rd_ack = 1'b0;
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_rd_data = 32'd0;
    m_wr_cnt = 32'd0; m_rd_cnt = 32'd0; m_stall_cnt = 32'd0;
    wr_granted = 1'b0; rd_granted = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("ctl", {28'd0, mem_write, mem_read, wr_ack, rd_ack},
             {28'd0, exp_write, exp_read, exp_wr_ack, exp_rd_ack});
    if (exp_write || exp_read) check_eq("mem_addr", mem_addr, exp_addr);
    if (exp_write) check_eq("mem_wdata", mem_wdata, exp_wdata);
    check_eq("rd_data", rd_data, exp_rd_data);
    check_eq("stat_wr", stat_wr_cnt, STATS_EN ? m_wr_cnt : 32'd0);
    check_eq("stat_rd", stat_rd_cnt, STATS_EN ? m_rd_cnt : 32'd0);
    check_eq("stat_stall", stat_stall_cnt, STATS_EN ? m_stall_cnt : 32'd0);
  endtask

  task automatic agent_update();
    if (exp_wr_ack) begin wr_pend = 1'b0; wr_granted = 1'b0; end
    if (exp_rd_ack) begin rd_pend = 1'b0; rd_granted = 1'b0; end
    if (wr_pend && !wr_granted && allow_withdraw && $urandom_range(0, 15) == 0) wr_pend = 1'b0;
    else if (!wr_pend) begin
      if (wr_plan.size() > 0) begin
        {wr_addr, wr_data} = wr_plan.pop_front(); wr_pend = 1'b1;
      end else if (auto_gen && $urandom_range(0, 3) == 0) begin
        wr_addr = $urandom; wr_data = $urandom; wr_pend = 1'b1;
      end
    end
    if (rd_pend && !rd_granted && allow_withdraw && $urandom_range(0, 15) == 0) rd_pend = 1'b0;
    else if (!rd_pend) begin
      if (rd_plan.size() > 0) begin
        rd_addr = rd_plan.pop_front(); rd_pend = 1'b1;
      end else if (auto_gen && $urandom_range(0, 3) == 0) begin
        rd_addr = $urandom; rd_pend = 1'b1;
      end
    end
    wr_req = wr_pend && !(wr_granted && allow_drop && $urandom_range(0, 3) == 0);
    rd_req = rd_pend && !(rd_granted && allow_drop && $urandom_range(0, 3) == 0);
  endtask

  // Predicts DUT outputs after the coming rising edge from the inputs now driven.
  task automatic model_step();
    mem_rdata  = rdata_fixed ? 32'h1234_5678 : $urandom;
    exp_wr_ack = 1'b0;
    exp_rd_ack = 1'b0;
    if (m_phase == PH_CMD) begin
      mem_waitrequest = (m_stall_left > 0);
      if (mem_waitrequest) begin
        m_stall_left--; m_stall_cnt++;
      end else begin
        exp_write = 1'b0; exp_read = 1'b0;
        if (m_side_rd) begin exp_rd_ack = 1'b1; exp_rd_data = mem_rdata; m_rd_cnt++; end
        else begin exp_wr_ack = 1'b1; m_wr_cnt++; end
        m_phase = PH_ACK;
      end
    end else begin
      mem_waitrequest = ($urandom_range(0, 1) == 1);  // meaningless outside a command
      if (m_phase == PH_ACK) m_phase = PH_READY;
      else if (wr_req || rd_req) begin
        if (wr_req && rd_req) m_side_rd = (m_burst < MAX_BURST) ? m_last_rd : !m_last_rd;
        else m_side_rd = rd_req;
        if (m_side_rd == m_last_rd) m_burst = (m_burst < 255) ? m_burst + 1 : 255;
        else m_burst = 1;
        m_last_rd = m_side_rd;
        exp_write = !m_side_rd;
        exp_read  = m_side_rd;
        exp_addr  = m_side_rd ? rd_addr : wr_addr;
        if (!m_side_rd) exp_wdata = wr_data;
        if (m_side_rd) rd_granted = 1'b1; else wr_granted = 1'b1;
        if (stall_plan.size() > 0) m_stall_left = stall_plan.pop_front();
        else if (rand_stall) m_stall_left = int'($urandom_range(0, 3));
        else m_stall_left = 0;
        m_phase = PH_CMD;
      end
    end
  endtask

  task automatic monitor();
    bit cmd_now;
    cmd_now = mem_write | mem_read;
    if (cmd_now && !prev_cmd) begin
      start_cyc.push_back(cyc);
      start_rd.push_back(mem_read);
    end
    prev_cmd = cmd_now;
    if (mem_write) wr_cmd_cyc++;
    if (mem_read) rd_cmd_cyc++;
    if (wr_ack) wr_ack_seen++;
    if (rd_ack) rd_ack_seen++;
    cyc++;
  endtask

  task automatic tick();
    agent_update();
    model_step();
    @(negedge ctrl_clk);
    check_outputs();
    monitor();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge ctrl_clk);
    check_outputs();
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    prev_cmd = 1'b0;
    reset_n  = 1'b1;
  endtask

  initial begin
    int base_a, base_b, base_c;
    do_reset();

    // single unstalled write
    wr_plan.push_back({32'h0000_0010, 32'hA5A5_A5A5});
    stall_plan.push_back(0);
    base_a = wr_cmd_cyc; base_b = wr_ack_seen;
    repeat (5) tick();
    check_eq("single_wr_cmd_cycles", 32'(wr_cmd_cyc - base_a), 32'd1);
    check_eq("single_wr_acks", 32'(wr_ack_seen - base_b), 32'd1);

    // read stalled five cycles
    rd_plan.push_back(32'h0000_0040);
    stall_plan.push_back(5);
    rdata_fixed = 1'b1;
    base_a = rd_cmd_cyc; base_c = int'(stat_stall_cnt);
    repeat (12) tick();
    rdata_fixed = 1'b0;
    check_eq("stalled_rd_cmd_cycles", 32'(rd_cmd_cyc - base_a), 32'd6);
    check_eq("stalled_rd_data", rd_data, 32'h1234_5678);
    check_eq("stalled_rd_stall_cnt", stat_stall_cnt - 32'(base_c), STATS_EN ? 32'd5 : 32'd0);

    // both sides held from reset: 8 writes, 8 reads, 8 writes
    do_reset();
    start_cyc.delete(); start_rd.delete();
    for (int i = 0; i < 16; i++) wr_plan.push_back({32'(i * 4), 32'($urandom)});
    for (int i = 0; i < 8; i++) rd_plan.push_back(32'(32'h1000 + i * 4));
    repeat (24 * 3 + 6) tick();
    check_eq("burst_grants", 32'(start_rd.size()), 32'd24);
    for (int i = 0; i < start_rd.size(); i++)
      check_eq("burst_order", 32'(start_rd[i]), 32'((i / 8) % 2));

    // write-only stream: back-to-back every 3 cycles
    start_cyc.delete(); start_rd.delete();
    for (int i = 0; i < 20; i++) wr_plan.push_back({32'($urandom), 32'($urandom)});
    repeat (20 * 3 + 4) tick();
    check_eq("wr_only_grants", 32'(start_rd.size()), 32'd20);
    for (int i = 0; i < start_rd.size(); i++) begin
      check_eq("wr_only_side", 32'(start_rd[i]), 32'd0);
      if (i > 0) check_eq("wr_only_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 32'd3);
    end

    // reset while a write is stalled
    wr_plan.push_back({32'h0000_0200, 32'hDEAD_BEEF});
    stall_plan.push_back(10);
    stall_plan.push_back(0);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_drop_write", 32'(mem_write), 32'd0);
    check_eq("async_no_ack", 32'(wr_ack), 32'd0);
    model_reset();
    @(negedge ctrl_clk);
    check_outputs();
    prev_cmd = 1'b0;
    reset_n  = 1'b1;
    base_b = wr_ack_seen;
    repeat (6) tick();
    check_eq("regrant_ack", 32'(wr_ack_seen - base_b), 32'd1);

    // random traffic with stalls, withdrawals and mid-command drops
    auto_gen = 1'b1; allow_withdraw = 1'b1; allow_drop = 1'b1; rand_stall = 1'b1;
    repeat (1500) tick();
    auto_gen = 1'b0; allow_withdraw = 1'b0; allow_drop = 1'b0;
    repeat (40) tick();
    check_eq("drained", {30'd0, wr_pend, rd_pend}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
